// File: rtl/comp_result_merger.sv
// Merges round-robin per-core compressed streams into one wide AXI4-Stream.
// Optional statistics counters are built when COMP_MERGER_STATS_EN is defined.
module comp_result_merger #(
  parameter int N_CORES  = 4,
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CORES*IN_BITS-1:0]    s_tdata,
  input  logic [N_CORES*IN_BITS/8-1:0]  s_tkeep,
  input  logic [N_CORES-1:0]            s_tlast,
  input  logic [N_CORES-1:0]            s_tvalid,
  output logic [N_CORES-1:0]            s_tready,
  output logic [OUT_BITS-1:0]           m_tdata,
  output logic [OUT_BITS/8-1:0]         m_tkeep,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready
`ifdef COMP_MERGER_STATS_EN
  ,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int R      = OUT_BITS / IN_BITS;
  localparam int KB     = IN_BITS / 8;
  localparam int CUR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int SLOT_W = $clog2(R);
  localparam logic [CUR_W-1:0]  LAST_CORE = CUR_W'(N_CORES - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(R - 1);

  logic [CUR_W-1:0]    cur_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic                sealed_reg;
  logic                p_last_reg;
  logic [IN_BITS-1:0]  p_data_reg [R];
  logic [KB-1:0]       p_keep_reg [R];

  logic [N_CORES-1:0]  core_sel;
  logic [IN_BITS-1:0]  in_data;
  logic [KB-1:0]       in_keep;
  logic                in_last;
  logic                in_valid;
  logic                room;
  logic                accept;
  logic                seal;
  logic                move;
  logic [OUT_BITS-1:0]   p_data_flat;
  logic [OUT_BITS/8-1:0] p_keep_flat;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      assign core_sel[gi] = (cur_reg == CUR_W'(gi));
      assign s_tready[gi] = core_sel[gi] & rst_n & room;
    end
    for (gi = 0; gi < R; gi++) begin : g_slot
      assign p_data_flat[gi*IN_BITS +: IN_BITS] = p_data_reg[gi];
      assign p_keep_flat[gi*KB +: KB]           = p_keep_reg[gi];
    end
  endgenerate

  always_comb begin
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (core_sel[i]) begin
        in_data  = s_tdata[i*IN_BITS +: IN_BITS];
        in_keep  = s_tkeep[i*KB +: KB];
        in_last  = s_tlast[i];
        in_valid = s_tvalid[i];
      end
    end
  end

  // P may accept whenever it is not holding a sealed word that cannot leave this cycle.
  assign room   = !sealed_reg || !m_tvalid || m_tready;
  assign accept = rst_n && in_valid && room;
  assign seal   = accept && ((slot_reg == LAST_SLOT) || in_last);
  assign move   = sealed_reg && (!m_tvalid || m_tready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_reg    <= '0;
      slot_reg   <= '0;
      sealed_reg <= 1'b0;
      p_last_reg <= 1'b0;
      for (int k = 0; k < R; k++) begin
        p_data_reg[k] <= '0;
        p_keep_reg[k] <= '0;
      end
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else begin
      if (move) begin
        m_tdata  <= p_data_flat;
        m_tkeep  <= p_keep_flat;
        m_tlast  <= p_last_reg;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (accept) begin
        // Writing slot 0 clears the rest so a short sealed word carries zero data/keep.
        for (int k = 0; k < R; k++) begin
          if (slot_reg == SLOT_W'(k)) begin
            p_data_reg[k] <= in_data;
            p_keep_reg[k] <= in_keep;
          end else if (slot_reg == '0) begin
            p_data_reg[k] <= '0;
            p_keep_reg[k] <= '0;
          end
        end
        slot_reg <= seal ? '0 : slot_reg + 1'b1;
        if (seal) p_last_reg <= in_last;
        if (in_last) cur_reg <= (cur_reg == LAST_CORE) ? '0 : cur_reg + 1'b1;
      end

      if (seal) sealed_reg <= 1'b1;
      else if (move) sealed_reg <= 1'b0;
    end
  end

`ifdef COMP_MERGER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 32'd1;
      if (in_valid && !room) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comp_result_merger.sv
// Randomized bench for comp_result_merger with a packet-level reference model.
// Statistics checks are compiled when COMP_MERGER_STATS_EN is defined.
module tb_comp_result_merger;

  localparam int N  = 4;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int R  = OW / IW;
  localparam int KW = IW / 8;
  localparam int OK = OW / 8;

  typedef struct packed {logic [IW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  typedef struct packed {logic [OW-1:0] d; logic [OK-1:0] k; logic l;} word_t;

  logic            clk;
  logic            rst_n;
  logic [N*IW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [OW-1:0]   m_tdata;
  logic [OK-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
`ifdef COMP_MERGER_STATS_EN
  logic [31:0]     pkt_count;
  logic [31:0]     stall_count;
`endif

  comp_result_merger #(.N_CORES(N), .IN_BITS(IW), .OUT_BITS(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
`ifdef COMP_MERGER_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t core_q [N][$];
  word_t exp_q [$];
  word_t got_q [$];
  bit    vld_hold [N];
  int    model_cur, trk_cur;
  int    proto_err, timed_out, stall_seen, first_acc, first_out;
  bit    use_gaps;

  // Reference: a packet is cut into R-beat words, the last word flagged with tlast.
  task automatic add_packet(input int core, input int nb, input int kmode);
    word_t w;
    beat_t b;
    int s;
    w = '0;
    s = 0;
    for (int j = 0; j < nb; j++) begin
      b.d = {$urandom, $urandom};
      b.k = (kmode == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if (kmode != 0 && j == nb - 1 && $urandom_range(0, 3) == 0) b.k = 8'h00;
      b.l = (j == nb - 1);
      core_q[core].push_back(b);
      w.d[s*IW +: IW] = b.d;
      w.k[s*KW +: KW] = b.k;
      s++;
      if (s == R || b.l) begin
        w.l = b.l;
        exp_q.push_back(w);
        w = '0;
        s = 0;
      end
    end
  endtask

  task automatic add_rr(input int nb, input int kmode);
    add_packet(model_cur, nb, kmode);
    model_cur = (model_cur + 1) % N;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      core_q[i].delete();
      vld_hold[i] = 1'b0;
    end
    exp_q.delete();
    got_q.delete();
    s_tvalid  = '0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tlast   = '0;
    model_cur = 0;
    trk_cur   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: ready high, 1: random ready, 2: low for 20 cycles, 3: low until 7 stalls seen
  task automatic run_traffic(input int max_cycles, input int mode, input int stop_acc);
    int cyc, acc;
    bit done, pstall, empty;
    word_t pw, w;
    cyc = 0; acc = 0; done = 0; pstall = 0;
    proto_err = 0; timed_out = 0; stall_seen = 0; first_acc = -1; first_out = -1;
    pw = '0;
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!vld_hold[i] && core_q[i].size() > 0 && (!use_gaps || $urandom_range(0, 3) != 0))
          vld_hold[i] = 1'b1;
        s_tvalid[i] = vld_hold[i];
        if (vld_hold[i]) begin
          s_tdata[i*IW +: IW] = core_q[i][0].d;
          s_tkeep[i*KW +: KW] = core_q[i][0].k;
          s_tlast[i]          = core_q[i][0].l;
        end else begin
          s_tdata[i*IW +: IW] = '0;
          s_tkeep[i*KW +: KW] = '0;
          s_tlast[i]          = 1'b0;
        end
      end
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 2) != 0);
        2:       m_tready = (cyc >= 20);
        default: m_tready = (stall_seen >= 7);
      endcase
      #1;
      if ($countones(s_tready) > 1) proto_err++;
      if (s_tready != '0 && s_tready != (N'(1) << trk_cur)) proto_err++;
      if (pstall && (!m_tvalid || {m_tdata, m_tkeep, m_tlast} !== pw)) proto_err++;
      pstall = m_tvalid && !m_tready;
      pw = {m_tdata, m_tkeep, m_tlast};
      if (s_tvalid[trk_cur] && !s_tready[trk_cur]) stall_seen++;
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) begin
          if (core_q[i][0].l) trk_cur = (trk_cur + 1) % N;
          void'(core_q[i].pop_front());
          vld_hold[i] = 1'b0;
          acc++;
          if (first_acc < 0) first_acc = cyc;
        end
      end
      if (m_tvalid && m_tready) begin
        w.d = m_tdata; w.k = m_tkeep; w.l = m_tlast;
        got_q.push_back(w);
        if (first_out < 0) first_out = cyc;
      end
      cyc++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (core_q[i].size() != 0 || vld_hold[i]) empty = 1'b0;
      if (stop_acc > 0) done = (acc >= stop_acc);
      else done = empty && (got_q.size() >= exp_q.size());
      if (!done && cyc >= max_cycles) begin
        timed_out = 1;
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    m_tready = 1'b1;
    s_tvalid = '1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (s_tready !== '0) $display("FAIL reset_s_tready got %b want 0000", s_tready);
    else n_pass++;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0)
      $display("FAIL reset_outputs got valid=%b keep=%h last=%b want all 0", m_tvalid, m_tkeep, m_tlast);
    else n_pass++;
`ifdef COMP_MERGER_STATS_EN
    n_checks++;
    if (pkt_count !== 32'd0 || stall_count !== 32'd0)
      $display("FAIL reset_counters got pkt=%0d stall=%0d want 0 0", pkt_count, stall_count);
    else n_pass++;
`endif
    rst_n = 1'b1;
    s_tvalid = '0;
    #1;
    n_checks++;
    if (s_tready !== 4'b0001) $display("FAIL post_reset_s_tready got %b want 0001", s_tready);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_two_packets();
    do_reset();
    use_gaps = 0;
    add_rr(8, 0);
    add_rr(3, 0);
    run_traffic(200, 0, 0);
    n_checks++;
    if (timed_out != 0 || got_q.size() != 2) $display("FAIL two_pkt_count got %0d words want 2", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL two_pkt_word%0d got keep=%h last=%b want keep=%h last=%b", i, got_q[i].k, got_q[i].l, exp_q[i].k, exp_q[i].l);
      else n_pass++;
    end
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0].k !== {OK{1'b1}} || got_q[0].l !== 1'b1) $display("FAIL two_pkt_first got keep=%h last=%b want all-ones 1", got_q[0].k, got_q[0].l);
      else n_pass++;
      n_checks++;
      if (got_q[1].k !== 64'h0000_0000_00FF_FFFF || got_q[1].l !== 1'b1) $display("FAIL two_pkt_second got keep=%h last=%b want 0000000000ffffff 1", got_q[1].k, got_q[1].l);
      else n_pass++;
    end
    $display("test_two_packets words=%0d", got_q.size());
  endtask

  task automatic test_order();
    do_reset();
    use_gaps = 1;
    for (int p = 0; p < 5; p++) add_rr($urandom_range(2, 12), 1);
    run_traffic(2000, 0, 0);
    n_checks++;
    if (timed_out != 0 || proto_err != 0 || got_q.size() != exp_q.size())
      $display("FAIL order_proto got err=%0d timeout=%0d words=%0d want 0 0 %0d", proto_err, timed_out, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL order_word%0d got keep=%h last=%b want keep=%h last=%b", i, got_q[i].k, got_q[i].l, exp_q[i].k, exp_q[i].l);
      else n_pass++;
    end
    $display("test_order words=%0d", got_q.size());
  endtask

  task automatic test_single_beat();
    do_reset();
    use_gaps = 0;
    for (int p = 0; p < 5; p++) add_rr(1, 0);
    run_traffic(500, 0, 0);
    n_checks++;
    if (first_out - first_acc != 2) $display("FAIL single_latency got %0d cycles want 2", first_out - first_acc);
    else n_pass++;
    n_checks++;
    if (timed_out != 0 || proto_err != 0 || got_q.size() != 5)
      $display("FAIL single_count got err=%0d words=%0d want 0 5", proto_err, got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].k !== 64'hFF || got_q[i].l !== 1'b1)
        $display("FAIL single_word%0d got keep=%h last=%b want keep=%h last=1", i, got_q[i].k, got_q[i].l, exp_q[i].k);
      else n_pass++;
    end
    $display("test_single_beat words=%0d", got_q.size());
  endtask

  task automatic test_backpressure();
    do_reset();
    use_gaps = 0;
    add_rr(32, 0);
    run_traffic(500, 2, 0);
    n_checks++;
    if (stall_seen == 0) $display("FAIL bp_stall got %0d stall cycles want >0", stall_seen);
    else n_pass++;
    n_checks++;
    if (timed_out != 0 || proto_err != 0 || got_q.size() != 4)
      $display("FAIL bp_count got err=%0d words=%0d want 0 4", proto_err, got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d got data=%h want %h", i, got_q[i].d, exp_q[i].d);
      else n_pass++;
    end
    $display("test_backpressure words=%0d stalls=%0d", got_q.size(), stall_seen);
  endtask

  task automatic test_mid_reset();
    do_reset();
    use_gaps = 0;
    add_packet(0, 8, 0);
    exp_q.delete();
    run_traffic(200, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 4'b0001 || got_q.size() != 0)
      $display("FAIL midreset_state got valid=%b ready=%b words=%0d want 0 0001 0", m_tvalid, s_tready, got_q.size());
    else n_pass++;
    add_rr(8, 1);
    run_traffic(200, 0, 0);
    n_checks++;
    if (timed_out != 0 || got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL midreset_packet got words=%0d want 1 matching word", got_q.size());
    else n_pass++;
    $display("test_mid_reset words=%0d", got_q.size());
  endtask

  task automatic test_random();
    do_reset();
    use_gaps = 1;
    for (int p = 0; p < 40; p++) add_rr($urandom_range(1, 20), 1);
    run_traffic(20000, 1, 0);
    n_checks++;
    if (timed_out != 0 || proto_err != 0 || got_q.size() != exp_q.size())
      $display("FAIL random_proto got err=%0d timeout=%0d words=%0d want 0 0 %0d", proto_err, timed_out, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL random_word%0d got keep=%h last=%b want keep=%h last=%b", i, got_q[i].k, got_q[i].l, exp_q[i].k, exp_q[i].l);
      else n_pass++;
    end
    $display("test_random words=%0d", got_q.size());
  endtask

`ifdef COMP_MERGER_STATS_EN
  task automatic test_stats();
    int words;
    do_reset();
    use_gaps = 0;
    for (int p = 0; p < 9; p++) add_rr(1, 0);
    run_traffic(500, 0, 0);
    words = got_q.size();
    add_rr(17, 0);
    run_traffic(500, 3, 0);
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size() || words != 9)
      $display("FAIL stats_words got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (pkt_count !== 32'd10) $display("FAIL stats_pkt got %0d want 10", pkt_count);
    else n_pass++;
    n_checks++;
    if (stall_count !== 32'd7) $display("FAIL stats_stall got %0d want 7", stall_count);
    else n_pass++;
    $display("test_stats pkt=%0d stall=%0d", pkt_count, stall_count);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    m_tready = 1'b0;
    use_gaps = 0;
    clear_all();
    test_reset();
    test_two_packets();
    test_order();
    test_single_beat();
    test_backpressure();
    test_mid_reset();
    test_random();
`ifdef COMP_MERGER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
